// File: rtl/fht_stream_top.sv
// ============================================================================
// fht_stream_top
//
// Streaming front/back end for an in-place FHT engine working on a banked
// RAM. It has three phases:
//   - LOAD: accepts N = 2^(A_BIT+NB_LOG2) signed samples. Each sample is
//     sign-extended to D_BIT bits and written to bank (n mod NB), address
//     (n / NB).
//   - START/WAIT: pulses oENG_START for one cycle, then waits for a rising
//     edge on iENG_RDY.
//   - UNLOAD: streams the N result words out in natural index order through
//     a 2-entry skid buffer.
//
// Optional feature macro: FHT_BITREV_LOAD_EN
//   When defined, the load index is bit-reversed over (A_BIT+NB_LOG2) bits
//   before the bank/address mapping. The unload order is natural either way.
//
// Handshake rule for every valid/ready pair in this block: a transfer
// happens on the rising clock edge where valid and ready are both 1. The
// sender holds its data and valid stable until that transfer occurs.
//
// Ports
//   iCLK        in   clock; everything is on the rising edge
//   iRESET      in   asynchronous active-low reset
//   iDATA       in   D_BIT-1  signed input sample
//   iVALID      in   iDATA valid
//   oREADY      out  a sample is accepted this cycle (LOAD only)
//   oWE         out  NB  one-hot bank write enable (combinational from handshake)
//   oADDR_WR    out  A_BIT  bank write address
//   oDATA_WR    out  D_BIT  sign-extended sample
//   oENG_START  out  one-cycle engine start pulse
//   iENG_RDY    in   engine ready/done level
//   oADDR_RD    out  A_BIT  read address common to all banks
//   iDATA_RD    in   NB*D_BIT  bank read data, bank 0 in the LSBs, 1-cycle latency
//   oDATA       out  D_BIT  result word
//   oVALID      out  oDATA valid
//   iREADY      in   downstream accepts oDATA
//   oLAST       out  oDATA is result index N-1
//   oBUSY       out  FSM not in IDLE
//   oDBG_STATE  out  3  current FSM state (IDLE=0 LOAD=1 START=2 WAIT=3 UNLOAD=4)
// ============================================================================
module fht_stream_top #(
    parameter int D_BIT   = 16,
    parameter int A_BIT   = 8,
    parameter int NB_LOG2 = 2
) (
    input  logic                              iCLK,
    input  logic                              iRESET,
    input  logic [D_BIT-2:0]                  iDATA,
    input  logic                              iVALID,
    output logic                              oREADY,
    output logic [(1<<NB_LOG2)-1:0]           oWE,
    output logic [A_BIT-1:0]                  oADDR_WR,
    output logic [D_BIT-1:0]                  oDATA_WR,
    output logic                              oENG_START,
    input  logic                              iENG_RDY,
    output logic [A_BIT-1:0]                  oADDR_RD,
    input  logic [(1<<NB_LOG2)*D_BIT-1:0]     iDATA_RD,
    output logic [D_BIT-1:0]                  oDATA,
    output logic                              oVALID,
    input  logic                              iREADY,
    output logic                              oLAST,
    output logic                              oBUSY,
    output logic [2:0]                        oDBG_STATE
);

    localparam int NB    = 1 << NB_LOG2;
    localparam int IDX_W = A_BIT + NB_LOG2;
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t state;

    // Registered FSM outputs
    logic ready_q;
    logic start_q;
    logic busy_q;

    // Load side
    logic [IDX_W-1:0]   wr_n;
    logic [IDX_W-1:0]   wr_idx;
    logic [NB_LOG2-1:0] wr_bank;
    logic               wr_hs;

    // Engine ready edge detect
    logic eng_rdy_q;

    // Read side
    logic [IDX_W-1:0]   rd_k;
    logic               rd_all;
    logic               rd_pend;
    logic               rd_pend_last;
    logic [NB_LOG2-1:0] rd_bank_q;
    logic [D_BIT-1:0]   rd_word;
    logic               issue;
    logic               pop;
    logic               frame_done;

    // 2-entry output buffer
    logic [D_BIT-1:0] buf_data [2];
    logic             buf_last [2];
    logic             buf_wp;
    logic             buf_rp;
    logic [1:0]       buf_cnt;

    // ------------------------------------------------------------------
    // Load path: write strobe and data are combinational from the handshake
    // ------------------------------------------------------------------
    assign wr_hs = iVALID & ready_q;

`ifdef FHT_BITREV_LOAD_EN
    always_comb begin
        wr_idx = '0;
        for (int i = 0; i < IDX_W; i++) begin
            wr_idx[i] = wr_n[IDX_W-1-i];
        end
    end
`else
    assign wr_idx = wr_n;
`endif

    assign wr_bank  = wr_idx[NB_LOG2-1:0];
    assign oADDR_WR = wr_idx[IDX_W-1:NB_LOG2];
    // Gated so the write bus reads zero whenever no write happens, reset included
    assign oDATA_WR = wr_hs ? {iDATA[D_BIT-2], iDATA} : '0;

    always_comb begin
        oWE = '0;
        for (int b = 0; b < NB; b++) begin
            oWE[b] = wr_hs && (wr_bank == NB_LOG2'(b));
        end
    end

    // ------------------------------------------------------------------
    // Unload control
    // ------------------------------------------------------------------
    assign pop        = (state == S_UNLOAD) && (buf_cnt != 2'd0) && iREADY;
    assign frame_done = pop && buf_last[buf_rp];

    // Issue a read only if the buffer still has room once the read already
    // in flight has landed and this cycle's pop has left. This keeps
    // buf_cnt + rd_pend <= 2 at all times.
    assign issue = (state == S_UNLOAD) && !rd_all &&
                   (({1'b0, buf_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));

    assign oADDR_RD = rd_k[IDX_W-1:NB_LOG2];

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NB; b++) begin
            if (rd_bank_q == NB_LOG2'(b)) begin
                rd_word = iDATA_RD[b*D_BIT +: D_BIT];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM with load counter and registered control outputs
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state     <= S_IDLE;
            ready_q   <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            wr_n      <= '0;
            eng_rdy_q <= 1'b0;
        end else begin
            eng_rdy_q <= iENG_RDY;
            start_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    state   <= S_LOAD;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                S_LOAD: begin
                    if (wr_hs) begin
                        // Counter wraps to 0 naturally after N-1
                        wr_n <= wr_n + IDX_ONE;
                        if (wr_n == '1) begin
                            state   <= S_START;
                            ready_q <= 1'b0;
                            start_q <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Edge, not level: a ready level left high from the
                    // previous frame must not end the wait early.
                    if (!eng_rdy_q && iENG_RDY) begin
                        state <= S_UNLOAD;
                    end
                end
                S_UNLOAD: begin
                    if (frame_done) begin
                        state   <= S_LOAD;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read issue, one-cycle RAM latency tracking and output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            rd_k         <= '0;
            rd_all       <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            rd_bank_q    <= '0;
            buf_wp       <= 1'b0;
            buf_rp       <= 1'b0;
            buf_cnt      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            rd_pend      <= issue;
            rd_pend_last <= issue && (rd_k == '1);
            rd_bank_q    <= rd_k[NB_LOG2-1:0];

            if (issue) begin
                rd_k <= rd_k + IDX_ONE;
                if (rd_k == '1) begin
                    rd_all <= 1'b1;
                end
            end

            // Data for the read issued last cycle is on iDATA_RD now
            if (rd_pend) begin
                buf_data[buf_wp] <= rd_word;
                buf_last[buf_wp] <= rd_pend_last;
                buf_wp           <= ~buf_wp;
            end

            if (pop) begin
                buf_rp <= ~buf_rp;
            end

            buf_cnt <= buf_cnt + {1'b0, rd_pend} - {1'b0, pop};

            // Last word gone: nothing is in flight, return everything to 0
            if (frame_done) begin
                rd_k    <= '0;
                rd_all  <= 1'b0;
                buf_wp  <= 1'b0;
                buf_rp  <= 1'b0;
                buf_cnt <= 2'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign oREADY     = ready_q;
    assign oENG_START = start_q;
    assign oBUSY      = busy_q;
    assign oDBG_STATE = state;
    assign oDATA      = buf_data[buf_rp];
    assign oVALID     = (buf_cnt != 2'd0);
    assign oLAST      = (buf_cnt != 2'd0) && buf_last[buf_rp];

endmodule

// File: tb/tb_fht_stream_top.sv
// ============================================================================
// tb_fht_stream_top
//
// Bench for fht_stream_top with A_BIT=2, NB_LOG2=2, D_BIT=16 (N=16).
// It models the banked RAM: load writes land in ram_a, and reads return a
// result image res_img that stands in for the engine's output. The expected
// load placement comes from the sample index, and the expected unload stream
// comes from the result image in natural index order.
// ============================================================================
module tb_fht_stream_top;

    localparam int D_BIT   = 16;
    localparam int A_BIT   = 2;
    localparam int NB_LOG2 = 2;
    localparam int NB      = 4;
    localparam int N       = 16;
    localparam int DEPTH   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [D_BIT-2:0]     i_data;
    logic                 i_valid;
    logic                 o_ready;
    logic [NB-1:0]        o_we;
    logic [A_BIT-1:0]     o_addr_wr;
    logic [D_BIT-1:0]     o_data_wr;
    logic                 o_eng_start;
    logic                 i_eng_rdy;
    logic [A_BIT-1:0]     o_addr_rd;
    logic [NB*D_BIT-1:0]  rd_data;
    logic [D_BIT-1:0]     o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_last;
    logic                 o_busy;
    logic [2:0]           o_dbg_state;

    fht_stream_top #(.D_BIT(D_BIT), .A_BIT(A_BIT), .NB_LOG2(NB_LOG2)) dut (
        .iCLK       (clk),
        .iRESET     (rst_n),
        .iDATA      (i_data),
        .iVALID     (i_valid),
        .oREADY     (o_ready),
        .oWE        (o_we),
        .oADDR_WR   (o_addr_wr),
        .oDATA_WR   (o_data_wr),
        .oENG_START (o_eng_start),
        .iENG_RDY   (i_eng_rdy),
        .oADDR_RD   (o_addr_rd),
        .iDATA_RD   (rd_data),
        .oDATA      (o_data),
        .oVALID     (o_valid),
        .iREADY     (i_ready),
        .oLAST      (o_last),
        .oBUSY      (o_busy),
        .oDBG_STATE (o_dbg_state)
    );

    // ---------------- RAM model ----------------
    logic [D_BIT-1:0] ram_a   [NB][DEPTH];   // written by the DUT load port
    logic [D_BIT-1:0] res_img [NB][DEPTH];   // engine result image, read back

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (o_we[b]) ram_a[b][o_addr_wr] <= o_data_wr;
            rd_data[b*D_BIT +: D_BIT] <= res_img[b][o_addr_rd];
        end
    end

    // ---------------- scoreboard ----------------
    logic [D_BIT-1:0] exp_q[$];
    logic [D_BIT-1:0] load_exp [N];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Physical index a load sample n ends up at
    function automatic int phys_idx(input int n);
`ifdef FHT_BITREV_LOAD_EN
        return {n[0], n[1], n[2], n[3]};
`else
        return n;
`endif
    endfunction

    task automatic check_reset_outputs();
        check("rst_ready",   o_ready,     0);
        check("rst_we",      o_we,        0);
        check("rst_start",   o_eng_start, 0);
        check("rst_valid",   o_valid,     0);
        check("rst_last",    o_last,      0);
        check("rst_busy",    o_busy,      0);
        check("rst_data",    o_data,      0);
        check("rst_data_wr", o_data_wr,   0);
        check("rst_addr_wr", o_addr_wr,   0);
        check("rst_addr_rd", o_addr_rd,   0);
        check("rst_state",   o_dbg_state, 0);
    endtask

    // ---------------- driver tasks ----------------
    // mode 0: samples 1..N with valid held high; 1: random with the two
    // sign-extension corner samples first; 2: random with gaps.
    task automatic load_samples(input int mode, input int nload);
        logic [D_BIT-2:0] s;
        int n = 0;
        int guard = 0;
        int idx;
        while (n < nload && guard < 400) begin
            @(negedge clk);
            guard++;
            if (mode == 0)                s = (D_BIT-1)'(n + 1);
            else if (mode == 1 && n == 0) s = 15'h4000;
            else if (mode == 1 && n == 1) s = 15'h3fff;
            else                          s = (D_BIT-1)'($urandom_range(0, 32767));
            i_data  = s;
            i_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (mode == 0 && n > 0) check("ready_load", o_ready, 1);
            if (i_valid && o_ready) begin
                idx = phys_idx(n);
                check("we",      o_we,      32'(1) << (idx % NB));
                check("addr_wr", o_addr_wr, idx / NB);
                check("data_wr", o_data_wr, {s[D_BIT-2], s});
                load_exp[idx] = {s[D_BIT-2], s};
                n++;
            end else begin
                check("we_idle", o_we, 0);
            end
        end
        if (n < nload) check("load_timeout", n, nload);
    endtask

    // mode 0: iREADY 1,0,0,1 repeating; 1: random; 2: always 1
    task automatic unload(input int mode);
        int pat [4] = '{1, 0, 0, 1};
        int got = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        logic [D_BIT-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic prev_stall = 1'b0;
        logic [D_BIT-1:0] e;
        while (got < N && cyc < 300) begin
            @(negedge clk);
            i_ready = (mode == 0) ? pat[cyc % 4][0] :
                      (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
            cyc++;
            #1;
            if (prev_stall) begin
                check("hold_valid", o_valid, 1);
                check("hold_data",  o_data,  prev_data);
                check("hold_last",  o_last,  prev_last);
            end
            if (o_valid) begin
                if (i_ready) begin
                    e = exp_q.pop_front();
                    check("data", o_data, e);
                    check("last", o_last, (got == N-1));
                    got++;
                    if (first < 0) first = cyc;
                    last = cyc;
                end
            end else begin
                check("last_novalid", o_last, 0);
            end
            prev_stall = o_valid & ~i_ready;
            prev_data  = o_data;
            prev_last  = o_last;
        end
        if (got < N) check("unload_timeout", got, N);
        @(negedge clk);
        i_ready = 1'b1;   // no effect outside UNLOAD
        #1;
        check("ready_after", o_ready, 1);
        check("valid_after", o_valid, 0);
        check("state_after", o_dbg_state, 1);
        i_ready = 1'b0;
        if (mode == 2) check("throughput", last - first, N - 1);
    endtask

    // emode 0: iENG_RDY high through START/WAIT, then low 3, then high
    // emode 1: iENG_RDY low, then high after a random delay
    task automatic run_frame(input int lmode, input int emode, input int umode);
        logic [D_BIT-1:0] v;
        i_eng_rdy = (emode == 0);
        exp_q.delete();
        load_samples(lmode, N);

        // START cycle: samples offered here must be ignored
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = (D_BIT-1)'($urandom_range(1, 32767));
        #1;
        check("start_pulse", o_eng_start, 1);
        check("ready_drop",  o_ready,     0);
        check("we_start",    o_we,        0);
        check("state_start", o_dbg_state, 2);
        @(negedge clk);
        #1;
        check("start_single", o_eng_start, 0);
        check("state_wait",   o_dbg_state, 3);
        check("we_wait",      o_we,        0);
        i_valid = 1'b0;

        for (int k = 0; k < N; k++)
            check("ram_img", ram_a[k % NB][k / NB], load_exp[k]);

        // Engine result image
        for (int k = 0; k < N; k++) begin
            v = (emode == 0) ? D_BIT'(k) : D_BIT'($urandom_range(0, 65535));
            res_img[k % NB][k / NB] = v;
            exp_q.push_back(v);
        end

        if (emode == 0) begin
            repeat (3) begin
                @(negedge clk); #1;
                check("wait_level_high", o_dbg_state, 3);
            end
            @(negedge clk);
            i_eng_rdy = 1'b0;
            repeat (3) begin
                #1;
                check("wait_level_low", o_dbg_state, 3);
                check("wait_no_valid",  o_valid,     0);
                @(negedge clk);
            end
            i_eng_rdy = 1'b1;
        end else begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            @(negedge clk);
            i_eng_rdy = 1'b1;
        end
        unload(umode);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b1;
        i_data    = 15'h1234;
        i_valid   = 1'b1;
        i_eng_rdy = 1'b0;
        i_ready   = 1'b1;
        #1 rst_n  = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs();
        @(negedge clk);
        i_valid = 1'b1;
        rst_n   = 1'b1;

        run_frame(0, 0, 0);
        run_frame(1, 1, 1);

        // Abandon a frame mid-load
        load_samples(2, 7);
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_data  = 15'h5a5a;
        i_ready = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        i_ready = 1'b0;
        rst_n   = 1'b1;

        run_frame(2, 1, 2);
        run_frame(2, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fht_stream_top.md
FHT_STREAM_TOP -- requirements
Module: fht_stream_top

Interface
REQ-001 Parameter D_BIT, default 16: width of stored/transformed words; the input sample is D_BIT-1 bits wide.
REQ-002 Parameter A_BIT, default 8: per-bank address width.
REQ-003 Parameter NB_LOG2, default 2: log2 of bank count NB; N = 2^(A_BIT+NB_LOG2) points.
REQ-004 iCLK  in  1  the single clock; all logic is on the rising edge.
REQ-005 iRESET  in  1  asynchronous, active-low reset.
REQ-006 iDATA  in  D_BIT-1  signed input sample.
REQ-007 iVALID  in  1  iDATA is valid.
REQ-008 oREADY  out  1  the block accepts a sample this cycle.
REQ-009 oWE  out  NB  one-hot bank write enable to the RAM(A) load port.
REQ-010 oADDR_WR  out  A_BIT  bank write address.
REQ-011 oDATA_WR  out  D_BIT  sign-extended sample to be written.
REQ-012 oENG_START  out  1  one-cycle start pulse to the transform engine.
REQ-013 iENG_RDY  in  1  engine ready/done level.
REQ-014 oADDR_RD  out  A_BIT  bank read address, common to all banks.
REQ-015 iDATA_RD  in  NB*D_BIT  concatenated bank read data, bank 0 in the LSBs, valid 1 cycle after oADDR_RD.
REQ-016 oDATA  out  D_BIT  result word.
REQ-017 oVALID  out  1  oDATA is valid.
REQ-018 iREADY  in  1  the downstream accepts oDATA.
REQ-019 oLAST  out  1  oDATA is result index N-1.
REQ-020 oBUSY  out  1  the state is not IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, START, WAIT and UNLOAD; IDLE goes to LOAD on the first cycle after reset release.
REQ-022 In LOAD: oREADY=1; each iVALID&oREADY handshake writes sample index n, with bank = n mod NB and address = n/NB; n increments by 1.
REQ-023 The write is combinational from the handshake: oWE[bank]=1 in the same cycle, oDATA_WR = {iDATA[MSB], iDATA}; oWE=0 otherwise.
REQ-024 On the handshake with n = N-1, the counter SHALL wrap to 0, the next state SHALL be START, and oREADY SHALL drop on the next cycle.
REQ-025 START SHALL last exactly 1 cycle with oENG_START=1, then go to WAIT.
REQ-026 WAIT SHALL go to UNLOAD only on a rising edge of iENG_RDY (registered low, current high), so a level already high at entry is ignored.
REQ-027 UNLOAD SHALL issue read index k = 0..N-1 in natural order: oADDR_RD = k/NB, and the bank selected for that read is k mod NB.
REQ-028 The read path SHALL have a 2-entry output buffer and SHALL issue a read only when a buffer slot is free after accounting for the read in flight; no word is lost or duplicated under any iREADY pattern.
REQ-029 Once the pipeline is full, throughput SHALL be 1 word/cycle while iREADY=1.
REQ-030 oDATA/oVALID/oLAST SHALL hold stable while oVALID&!iREADY.
REQ-031 After the handshake on oLAST, the FSM SHALL return to LOAD with all counters at 0.
REQ-032 iVALID outside LOAD SHALL be ignored, with oREADY=0.
REQ-033 iREADY outside UNLOAD has no effect.

Reset
REQ-034 iRESET low SHALL immediately force IDLE with all counters 0, the buffer empty, and oREADY, oWE, oENG_START, oVALID, oLAST and oBUSY all 0; oDATA, oDATA_WR, oADDR_WR and oADDR_RD SHALL be 0.
REQ-035 Reset asserted mid-LOAD or mid-UNLOAD SHALL abandon the frame; the first frame after release starts at n=0.

Configuration
REQ-036 Macro FHT_BITREV_LOAD_EN: when defined, in LOAD the index n SHALL be replaced by its (A_BIT+NB_LOG2)-bit bit-reversal before the bank/address mapping; when undefined, natural order is used. Unload order is natural in both cases.

Verification (bench: A_BIT=2, NB_LOG2=2, N=16, D_BIT=16)
REQ-037 Load 16 samples 0x0001..0x0010 with iVALID held high -> oWE one-hot cycles 1,2,4,8 repeating; oADDR_WR 0,0,0,0,1,...,3; oREADY low 1 cycle after the 16th sample; oENG_START is a single pulse.
REQ-038 Sample 0x4000 (15-bit negative) -> oDATA_WR=0xC000; sample 0x3FFF -> 0x3FFF.
REQ-039 iENG_RDY held high through START/WAIT, then low 3 cycles, then high -> UNLOAD starts only after the rising edge.
REQ-040 A RAM model returning value k at index k, with iREADY toggling 1,0,0,1 -> oDATA sequence exactly 0..15, no gaps or repeats, oLAST only with 15, then oREADY=1.
REQ-041 Reset pulsed after 7 loaded samples -> all outputs 0; the next frame writes sample 0 to bank 0, address 0.
REQ-042 With FHT_BITREV_LOAD_EN defined, sample n=1 -> bank 0, address 2 (index 8); n=3 -> bank 0, address 3 (index 12).
